serial_rx_fifo: RTL and testbench

//  Serial frame receiver with DEPTH-entry byte buffer; receive end of the team's 1-bit serial link.

---
 rtl/serial_rx_fifo_pkg.sv | 6 +
 rtl/serial_rx_fifo_fifo.sv | 61 ++++++
 rtl/serial_rx_fifo.sv | 78 +++++++
 tb/tb_serial_rx_fifo.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_rx_fifo_pkg.sv
// serial_rx_fifo_pkg: line levels and deframing FSM states shared by the serial link blocks
package serial_rx_fifo_pkg;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} rx_state_e;
endpackage

// File: rtl/serial_rx_fifo_fifo.sv
// sync_fifo: DEPTH-entry word buffer with wrapping pointers, registered count/flags and registered read
//   wr_en/wr_data push (caller guarantees room), rd_en pops when not empty,
//   rd_data/rd_vld return the popped word one cycle later, empty/full/count describe occupancy
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 123,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_vld,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count
);
  localparam logic [DEPTH_BITS-1:0] LAST = DEPTH_BITS'(DEPTH - 1);
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d, empty_q, empty_d, full_q, full_d, pop;
  always_comb begin
    pop       = rd_en && !empty_q;
    wr_ptr_d  = wr_en ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + DEPTH_BITS'(1)) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + DEPTH_BITS'(1)) : rd_ptr_q;
    count_d   = count_q + (DEPTH_BITS+1)'(wr_en) - (DEPTH_BITS+1)'(pop);
    empty_d   = count_d == '0;
    full_d    = count_d == (DEPTH_BITS+1)'(DEPTH);
    rd_data_d = pop ? mem[rd_ptr_q] : rd_data_q;
    rd_vld_d  = pop;
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
endmodule

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: deframes start/WIDTH data/stop on din_vld strobes and buffers good words
//   din/din_vld serial input, rd_en pops into dout/dout_vld, empty/full/count show occupancy,
//   frame_err pulses on a bad stop bit, ovf_err pulses when a good word finds the buffer full
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 123,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_vld,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_vld,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_BITS:0] count,
  output logic                frame_err,
  output logic                ovf_err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  rx_state_e        state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d, ovf_err_q, ovf_err_d, wr_req, wr_en;
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_req      = 1'b0;
    frame_err_d = 1'b0;
    if (din_vld)
      case (state_q)
        IDLE: begin
          state_d   = din == START_BIT ? DATA : IDLE;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d   = {din, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CW'(1);
          state_d   = bit_cnt_q == LAST_BIT ? STOP : DATA;
        end
        STOP: begin
          state_d     = IDLE;
          wr_req      = din == STOP_BIT;
          frame_err_d = din != STOP_BIT;
        end
        default: state_d = IDLE;
      endcase
    // a full buffer still takes the word when a pop frees a slot on the same edge
    ovf_err_d = wr_req && full && !rd_en;
    wr_en     = wr_req && !ovf_err_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(shift_d), .rd_en(rd_en),
    .rd_data(dout), .rd_vld(dout_vld), .empty(empty), .full(full), .count(count)
  );
endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed frames and pops against hand-computed results
module tb_serial_rx_fifo;
  logic       clk = 1'b0, rst_n = 1'b0, din = 1'b1, din_vld = 1'b0, rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_vld, empty, full, frame_err, ovf_err, fe_s, oe_s;
  logic [7:0] count;
  int         n_chk = 0, n_err = 0;
  serial_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .rd_en(rd_en),
    .dout(dout), .dout_vld(dout_vld), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input int gap);
    din = b;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int i = 0; i < gap; i++) begin
      din = ~din;
      tick();
    end
  endtask
  task automatic send_frame(input logic [7:0] v, input logic stop, input int gap, input logic rd);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
    din = stop;
    din_vld = 1'b1;
    rd_en = rd;
    tick();
    fe_s = frame_err;
    oe_s = ovf_err;
    din_vld = 1'b0;
    rd_en = 1'b0;
    din = 1'b1;
    repeat (gap) tick();
  endtask
  task automatic pop(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, dout_vld, 1);
    chk({tag, "_dout"}, dout, exp);
  endtask
  initial begin
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_errs", {frame_err, ovf_err}, 0);
    rst_n = 1'b1;
    tick();
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    chk("t1_ferr", fe_s, 0);
    pop("t1_pop", 8'hA5);
    chk("t1_count0", count, 0);
    chk("t1_empty1", empty, 1);
    tick();
    chk("t1_vld_pulse", dout_vld, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_rd_empty_vld", dout_vld, 0);
    chk("t1_rd_empty_hold", dout, 8'hA5);
    send_frame(8'hA5, 1'b1, 2, 1'b0);
    chk("t2_count", count, 1);
    pop("t2_pop", 8'hA5);
    chk("t2_empty", empty, 1);
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    chk("t3_ferr", fe_s, 1);
    chk("t3_oerr", oe_s, 0);
    chk("t3_count", count, 0);
    tick();
    chk("t3_ferr_pulse", frame_err, 0);
    send_frame(8'h11, 1'b1, 0, 1'b0);
    chk("t3_good_ferr", fe_s, 0);
    pop("t3_pop", 8'h11);
    for (int i = 0; i < 123; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
    chk("t4_full", full, 1);
    chk("t4_count", count, 123);
    send_frame(8'hFF, 1'b1, 0, 1'b0);
    chk("t4_ovf", oe_s, 1);
    chk("t4_ovf_ferr", fe_s, 0);
    chk("t4_count_ovf", count, 123);
    tick();
    chk("t4_ovf_pulse", ovf_err, 0);
    for (int i = 0; i < 123; i++) pop("t4_pop", 8'(i));
    chk("t4_empty", empty, 1);
    chk("t4_count0", count, 0);
    chk("t4_notfull", full, 0);
    for (int i = 0; i < 123; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
    chk("t5_full", full, 1);
    send_frame(8'h77, 1'b1, 0, 1'b1);
    chk("t5_ovf", oe_s, 0);
    chk("t5_count", count, 123);
    chk("t5_full_kept", full, 1);
    chk("t5_head", dout, 0);
    for (int i = 1; i < 123; i++) pop("t5_pop", 8'(i));
    pop("t5_last", 8'h77);
    chk("t5_empty", empty, 1);
    send_frame(8'h42, 1'b1, 0, 1'b0);
    pop("t6_pre", 8'h42);
    send_frame(8'h42, 1'b1, 0, 1'b0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_vld", dout_vld, 0);
    chk("t6_rst_errs", {frame_err, ovf_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    chk("t6_ferr", fe_s, 0);
    chk("t6_count", count, 1);
    pop("t6_pop", 8'h5A);
    chk("t6_empty", empty, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
